// File: rtl/rv_host_port_if.sv
// Host/console port bus: uRV dm_* data-memory bus plus the TX byte stream and completion outputs.
// Latency: none (wiring only).
// Backpressure: dm_ready_o stalls the CPU store; tx_ready_i throttles the byte stream.
interface rv_host_port_if;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic [31:0] dm_data_l_o;
  logic        dm_store_done_o;
  logic        dm_load_done_o;
  logic        dm_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        test_done_o;
  logic [31:0] test_code_o;

  // Peripheral side
  modport slave (
    input  dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i, tx_ready_i,
    output dm_data_l_o, dm_store_done_o, dm_load_done_o, dm_ready_o,
           tx_data_o, tx_valid_o, test_done_o, test_code_o
  );

  // CPU / sink side
  modport master (
    output dm_addr_i, dm_data_s_i, dm_data_select_i, dm_store_i, dm_load_i, tx_ready_i,
    input  dm_data_l_o, dm_store_done_o, dm_load_done_o, dm_ready_o,
           tx_data_o, tx_valid_o, test_done_o, test_code_o
  );
endinterface

// File: rtl/rv_host_port.sv
// Host/console peripheral: TX store -> byte FIFO -> valid/ready stream; DONE store latches a sticky completion code.
// Latency: store/load done pulses one cycle after acceptance; a pushed byte is visible on the stream one cycle after push.
// Backpressure: TX store into a full FIFO drops dm_ready_o until the byte fits. Option macro RV_HOST_PORT_DRAIN_ON_DONE_EN.
module rv_host_port #(
  parameter logic [31:0] g_base_addr  = 32'h0010_0000,
  parameter int          g_fifo_depth = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  rv_host_port_if.slave bus
);

  localparam int            AW      = $clog2(g_fifo_depth);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(g_fifo_depth);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_STALL = 1'b1;

  localparam logic [1:0] OFF_TX     = 2'd0;
  localparam logic [1:0] OFF_DONE   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_CODE   = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [g_fifo_depth];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // Control state
  logic [0:0]  state_q, state_d;
  logic [7:0]  stall_byte_q, stall_byte_d;
  logic        store_done_q, store_done_d;
  logic        load_done_q, load_done_d;
  logic [31:0] data_l_q, data_l_d;
  logic        done_req_q, done_req_d;
  logic        test_done_q, test_done_d;
  logic [31:0] code_q, code_d;

  logic        hit, st_hit, ld_hit, full, empty, push, pop;
  logic [1:0]  offset;
  logic [7:0]  push_byte;
  logic [31:0] cnt_ext, status_w;
  logic        unused_bits;

  assign hit    = (bus.dm_addr_i[31:4] == g_base_addr[31:4]);
  assign offset = bus.dm_addr_i[3:2];
  assign st_hit = bus.dm_store_i && hit;
  // Loads are ignored while a TX store is stalled, like every other bus input
  assign ld_hit = (state_q == S_IDLE) && bus.dm_load_i && hit;

  // Full comes from the registered count, so a same-cycle pop never admits a push into a full FIFO
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign pop   = !empty && bus.tx_ready_i;

  assign cnt_ext  = 32'(count_q);
  assign status_w = {16'h0, cnt_ext[7:0], 5'b0, full, empty, test_done_q};

  assign unused_bits = ^{bus.dm_addr_i[1:0], bus.dm_data_select_i[3:1], bus.dm_data_s_i[31:8] & 24'h0, cnt_ext[31:8]};

  // Store decode and IDLE/STALL sequencing
  always_comb begin
    state_d      = state_q;
    stall_byte_d = stall_byte_q;
    push         = 1'b0;
    push_byte    = bus.dm_data_s_i[7:0];
    store_done_d = 1'b0;
    done_req_d   = done_req_q;
    code_d       = code_q;
    case (state_q)
      S_IDLE: begin
        if (st_hit) begin
          case (offset)
            OFF_TX: begin
              if (bus.dm_data_select_i[0] && full) begin
                state_d      = S_STALL;
                stall_byte_d = bus.dm_data_s_i[7:0];
              end else begin
                push         = bus.dm_data_select_i[0];
                store_done_d = 1'b1;
              end
            end
            OFF_DONE: begin
              // First completion code wins; later DONE stores only complete
              if (!done_req_q) begin
                done_req_d = 1'b1;
                code_d     = bus.dm_data_s_i;
              end
              store_done_d = 1'b1;
            end
            default: store_done_d = 1'b1;
          endcase
        end
      end
      S_STALL: begin
        push_byte = stall_byte_q;
        if (!full) begin
          push         = 1'b1;
          store_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Load response: register read data, zero when not answering a load
  always_comb begin
    load_done_d = ld_hit;
    data_l_d    = 32'h0;
    if (ld_hit) begin
      case (offset)
        OFF_STATUS: data_l_d = status_w;
        OFF_CODE:   data_l_d = code_q;
        default:    data_l_d = 32'h0;
      endcase
    end
  end

  // Completion flag: either follows the DONE write directly or waits for the FIFO to drain
  always_comb begin
`ifdef RV_HOST_PORT_DRAIN_ON_DONE_EN
    test_done_d = test_done_q | (done_req_q & empty);
`else
    test_done_d = done_req_d;
`endif
  end

  // Occupancy next-state from push/pop pair
  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      stall_byte_q <= 8'h0;
      store_done_q <= 1'b0;
      load_done_q  <= 1'b0;
      data_l_q     <= 32'h0;
      done_req_q   <= 1'b0;
      test_done_q  <= 1'b0;
      code_q       <= 32'h0;
    end else begin
      state_q      <= state_d;
      stall_byte_q <= stall_byte_d;
      store_done_q <= store_done_d;
      load_done_q  <= load_done_d;
      data_l_q     <= data_l_d;
      done_req_q   <= done_req_d;
      test_done_q  <= test_done_d;
      code_q       <= code_d;
    end
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage; contents are masked by the empty flag so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= push_byte;
  end

  assign bus.dm_data_l_o     = data_l_q;
  assign bus.dm_store_done_o = store_done_q;
  assign bus.dm_load_done_o  = load_done_q;
  assign bus.dm_ready_o      = (state_q == S_IDLE);
  assign bus.tx_valid_o      = !empty;
  assign bus.tx_data_o       = empty ? 8'h0 : mem_q[rd_ptr_q];
  assign bus.test_done_o     = test_done_q;
  assign bus.test_code_o     = code_q;

endmodule

// File: tb/tb_rv_host_port.sv
// Testbench for rv_host_port: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model tracks bytes as entering the FIFO when their store completes.
// Backpressure: tx_ready_i is driven low, high or randomly per cycle.
module tb_rv_host_port;
  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam int          DEPTH = 16;
`ifdef RV_HOST_PORT_DRAIN_ON_DONE_EN
  localparam bit DRAIN = 1'b1;
`else
  localparam bit DRAIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv_host_port_if bus ();

  rv_host_port #(.g_base_addr(BASE), .g_fifo_depth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          dreq_m, tdone_m;
  logic [31:0] code_m;
  int          exp_sd, exp_ld, pop_cnt;
  bit          pend_push, pend_done;
  logic [7:0]  pend_byte;
  logic [31:0] pend_code;
  bit          sd, ld, rnd_rdy;
  logic [31:0] ld_data;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {16'h0, 8'(q.size()), 5'b0, q.size() == DEPTH, q.size() == 0, tdone_m};
  endfunction

  // One clock: pop check before the edge, model update and output checks after it
  task automatic cyc();
    bit was_rst, drain_fire;
    was_rst    = rst;
    drain_fire = dreq_m && (q.size() == 0);
    if (!was_rst && bus.tx_valid_o && bus.tx_ready_i && q.size() > 0) begin
      chk("tx_data", 32'(bus.tx_data_o), 32'(q.pop_front()));
      pop_cnt++;
    end
    @(negedge clk);
    sd      = bus.dm_store_done_o;
    ld      = bus.dm_load_done_o;
    ld_data = bus.dm_data_l_o;
    if (was_rst) begin
      q.delete();
      dreq_m = 0; tdone_m = 0; code_m = 0;
      pend_push = 0; pend_done = 0; exp_sd = 0; exp_ld = 0;
    end else begin
      if (sd) begin
        chk("store_done_expected", 32'(exp_sd > 0), 1);
        if (exp_sd > 0) exp_sd--;
        if (pend_push) begin q.push_back(pend_byte); pend_push = 0; end
        if (pend_done) begin
          if (!dreq_m) begin dreq_m = 1; code_m = pend_code; end
          pend_done = 0;
        end
      end
      if (ld) begin
        chk("load_done_expected", 32'(exp_ld > 0), 1);
        if (exp_ld > 0) exp_ld--;
      end
      if (DRAIN) begin
        if (drain_fire) tdone_m = 1;
      end else begin
        tdone_m = dreq_m;
      end
    end
    chk("tx_valid", 32'(bus.tx_valid_o), 32'(q.size() != 0));
    chk("test_done", 32'(bus.test_done_o), 32'(tdone_m));
    chk("test_code", bus.test_code_o, code_m);
    if (rnd_rdy) bus.tx_ready_i = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.dm_store_i = 1'b0;
    bus.dm_load_i  = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    bit hit, stall;
    int n;
    hit   = (a[31:4] == BASE[31:4]);
    stall = hit && (a[3:2] == 2'd0) && sel[0] && (q.size() == DEPTH);
    if (hit) begin
      exp_sd++;
      if (a[3:2] == 2'd0 && sel[0]) begin pend_push = 1; pend_byte = d[7:0]; end
      if (a[3:2] == 2'd1) begin pend_done = 1; pend_code = d; end
    end
    bus.dm_addr_i = a; bus.dm_data_s_i = d; bus.dm_data_select_i = sel; bus.dm_store_i = 1'b1;
    cyc();
    bus.dm_store_i = 1'b0;
    if (!hit) chk("miss_store_done", 32'(sd), 0);
    else if (!stall) chk("store_done_lat", 32'(sd), 1);
    else begin
      chk("stall_ready", 32'(bus.dm_ready_o), 0);
      chk("stall_done_held", 32'(sd), 0);
      n = 0;
      while (!sd && n < 300) begin cyc(); n++; end
      chk("stall_release_done", 32'(sd), 1);
      chk("stall_release_ready", 32'(bus.dm_ready_o), 1);
    end
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bit hit;
    hit = (a[31:4] == BASE[31:4]);
    if (hit) exp_ld++;
    bus.dm_addr_i = a; bus.dm_load_i = 1'b1;
    cyc();
    bus.dm_load_i = 1'b0;
    if (hit) begin
      chk({tag, "_done"}, 32'(ld), 1);
      chk(tag, ld_data, exp);
    end else begin
      chk({tag, "_miss"}, 32'(ld), 0);
    end
  endtask

  // Issue a TX store into a full FIFO and leave it stalled
  task automatic start_stall(input logic [7:0] b);
    exp_sd++; pend_push = 1; pend_byte = b;
    bus.dm_addr_i = BASE; bus.dm_data_s_i = {24'h0, b}; bus.dm_data_select_i = 4'hF; bus.dm_store_i = 1'b1;
    cyc();
    bus.dm_store_i = 1'b0;
    chk("stall_ready_low", 32'(bus.dm_ready_o), 0);
    chk("stall_no_done", 32'(sd), 0);
  endtask

  initial begin
    int r, p0;
    logic [31:0] a;
    bus.dm_addr_i = '0; bus.dm_data_s_i = '0; bus.dm_data_select_i = '0;
    bus.dm_store_i = 1'b0; bus.dm_load_i = 1'b0; bus.tx_ready_i = 1'b0;
    rnd_rdy = 0; pop_cnt = 0;

    // Reset values
    do_reset();
    chk("rst_data_l", bus.dm_data_l_o, 0);
    chk("rst_store_done", 32'(bus.dm_store_done_o), 0);
    chk("rst_load_done", 32'(bus.dm_load_done_o), 0);
    chk("rst_ready", 32'(bus.dm_ready_o), 1);
    chk("rst_tx_valid", 32'(bus.tx_valid_o), 0);
    chk("rst_tx_data", 32'(bus.tx_data_o), 0);
    chk("rst_test_done", 32'(bus.test_done_o), 0);
    chk("rst_test_code", bus.test_code_o, 0);

    // Single character with sink ready
    bus.tx_ready_i = 1'b1;
    do_store(BASE, 32'h41, 4'hF);
    chk("char_data", 32'(bus.tx_data_o), 32'h41);
    cyc();
    chk("char_gone", 32'(bus.tx_valid_o), 0);
    do_load("status_idle", BASE + 32'h8, 32'h0000_0002);

    // Fill to 16, 17th stalls, releases one cycle after the first pop
    bus.tx_ready_i = 1'b0;
    p0 = pop_cnt;
    for (int i = 0; i < DEPTH; i++) do_store(BASE, 32'(8'h60 + i), 4'hF);
    do_load("status_full", BASE + 32'h8, 32'h0000_1004);
    start_stall(8'hA5);
    repeat (3) begin cyc(); chk("stall_hold", 32'(bus.dm_ready_o), 0); end
    bus.tx_ready_i = 1'b1;
    cyc();
    chk("stall_after_pop", 32'(bus.dm_ready_o), 0);
    cyc();
    chk("stall_cleared_ready", 32'(bus.dm_ready_o), 1);
    chk("stall_cleared_done", 32'(sd), 1);
    repeat (20) cyc();
    chk("stall_all_popped", 32'(pop_cnt - p0), 17);

    // Completion code: first wins
    do_store(BASE + 32'h4, 32'hDEAD_BEEF, 4'hF);
    do_store(BASE + 32'h4, 32'h1, 4'hF);
    cyc();
    chk("done_code", bus.test_code_o, 32'hDEAD_BEEF);
    chk("done_flag", 32'(bus.test_done_o), 1);
    do_load("code_rd", BASE + 32'hC, 32'hDEAD_BEEF);
    do_load("tx_rd", BASE, 0);
    do_load("done_rd", BASE + 32'h4, 0);
    do_load("status_done", BASE + 32'h8, 32'h0000_0003);

    // DONE with bytes queued: drain behaviour
    do_reset();
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) do_store(BASE, 32'(8'h30 + i), 4'hF);
    do_store(BASE + 32'h4, 32'h5, 4'hF);
    chk("drain_code", bus.test_code_o, 32'h5);
    chk("drain_flag_early", 32'(bus.test_done_o), 32'(!DRAIN));
    bus.tx_ready_i = 1'b1;
    repeat (3) cyc();
    chk("drain_flag_at_empty", 32'(bus.test_done_o), 32'(!DRAIN));
    cyc();
    chk("drain_flag_final", 32'(bus.test_done_o), 1);

    // Push and pop together at count 5; misses and lane0-clear stores
    do_reset();
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) do_store(BASE, 32'(8'h50 + i), 4'hF);
    bus.tx_ready_i = 1'b1;
    do_store(BASE, 32'h66, 4'hF);
    bus.tx_ready_i = 1'b0;
    do_load("status_pushpop", BASE + 32'h8, 32'h0000_0500);
    do_store(BASE + 32'h10, 32'h77, 4'hF);
    cyc();
    chk("miss_no_late_done", 32'(sd), 0);
    do_load("miss_load", BASE + 32'h10, 0);
    do_store(BASE, 32'h78, 4'b1110);
    do_store(BASE + 32'h8, 32'hFFFF_FFFF, 4'hF);
    do_load("status_after_miss", BASE + 32'h8, status_exp());
    chk("count_five", 32'(ld_data[15:8]), 5);

    // Reset in the middle of a stall
    do_reset();
    do_store(BASE + 32'h4, 32'h99, 4'hF);
    bus.tx_ready_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_store(BASE, 32'(i), 4'hF);
    start_stall(8'hEE);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rststall_ready", 32'(bus.dm_ready_o), 1);
    chk("rststall_done_flag", 32'(bus.test_done_o), 0);
    chk("rststall_no_done", 32'(sd), 0);
    repeat (3) begin cyc(); chk("rststall_quiet", 32'(sd), 0); end

    // Randomized traffic
    do_reset();
    rnd_rdy = 1;
    for (int it = 0; it < 500; it++) begin
      r = $urandom_range(0, 99);
      if (r < 55) do_store(BASE, $urandom, (r < 45) ? 4'hF : 4'($urandom_range(0, 15)));
      else if (r < 65) do_load("rnd_status", BASE + 32'h8, status_exp());
      else if (r < 72) do_load("rnd_code", BASE + 32'hC, code_m);
      else if (r < 78) begin
        a = $urandom;
        if (a[31:4] == BASE[31:4]) a = a ^ 32'h8000_0000;
        do_store(a, $urandom, 4'hF);
      end
      else if (r < 82) do_store(BASE + 32'h4, $urandom, 4'($urandom_range(0, 15)));
      else if (r < 86) do_store(BASE + 32'h8 + 32'(4 * $urandom_range(0, 1)), $urandom, 4'hF);
      else cyc();
    end
    rnd_rdy = 0;
    bus.tx_ready_i = 1'b1;
    repeat (DEPTH + 4) cyc();
    do_load("final_status", BASE + 32'h8, status_exp());
    chk("final_pending_stores", 32'(exp_sd), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rv_host_port.md
# rv_host_port

Memory-mapped host/console peripheral on the uRV data-memory bus, replacing the behavioural console and test-complete decode in simulation benches. CPU stores to the TX register push characters into a FIFO drained over a valid/ready byte stream; a store to the DONE register latches a completion code and raises a sticky done flag. Sits directly downstream of `rv_cpu` on the dm_* interface, alongside the data RAM.

## Interface
- `g_base_addr`, 32'h0010_0000: base of the 16-byte register window (TX +0x0, DONE +0x4, STATUS +0x8, CODE +0xC).
- `g_fifo_depth`, 16: TX FIFO entries; power of 2, 2..256.
- `clk_i` in 1: single clock, all logic rising-edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `dm_addr_i` in 32: byte address from CPU.
- `dm_data_s_i` in 32: store data.
- `dm_data_select_i` in 4: byte-lane enables.
- `dm_store_i` in 1: store request.
- `dm_load_i` in 1: load request.
- `dm_data_l_o` out 32: load data.
- `dm_store_done_o` out 1: store completion pulse.
- `dm_load_done_o` out 1: load completion pulse.
- `dm_ready_o` out 1: low while a TX store is stalled.
- `tx_data_o` out 8: character at FIFO head.
- `tx_valid_o` out 1: FIFO non-empty.
- `tx_ready_i` in 1: sink accepts character.
- `test_done_o` out 1: sticky completion flag.
- `test_code_o` out 32: latched completion code.

## Operation
- Hit = `dm_addr_i[31:4] == g_base_addr[31:4]`; offset = `dm_addr_i[3:2]`; misses are ignored (no done pulses, no state change).
- FSM: IDLE, STALL.
  - IDLE, store hit TX, lane0 set, FIFO not full: push `dm_data_s_i[7:0]`, pulse store_done next cycle.
  - IDLE, store hit TX, FIFO full: go STALL, hold captured byte, `dm_ready_o`=0.
  - STALL: push captured byte when not full; then store_done pulse, `dm_ready_o`=1, back to IDLE. Bus inputs ignored in STALL.
  - Store to TX with lane0 clear: no push, store_done still pulses.
- DONE store (any lanes): if `test_done_o`=0, `test_code_o` <= `dm_data_s_i` and done sets; if already set, ignored (first code wins). store_done pulses.
- STATUS/CODE stores: ignored, store_done pulses.
- Loads: STATUS = {16'b0, count[7:0], 5'b0, full, empty, test_done}; CODE = `test_code_o`; TX/DONE read 0. Data and `dm_load_done_o` one cycle after request.
- Pop: `tx_valid_o && tx_ready_i`. Push and pop same cycle: both occur, count unchanged. Full uses registered count; a same-cycle pop does not admit a push while full (push waits one cycle).
- Count width log2(depth)+1; pointers wrap modulo depth.

## Timing
- Reset values: `dm_data_l_o`=0, both done pulses 0, `dm_ready_o`=1, `tx_valid_o`=0, `tx_data_o`=0, `test_done_o`=0, `test_code_o`=0; FIFO empty, FSM IDLE.
- `rst_i` mid-operation (incl. STALL): FIFO flushed, stalled byte dropped, no store_done issued, all outputs at reset values after the sampling edge.
- Store latency: done pulse one cycle after acceptance; pushed byte visible on `tx_data_o`/`tx_valid_o` one cycle after push if FIFO was empty.
- Done pulses are exactly one cycle wide; one per accepted request.

## Configuration
- `RV_HOST_PORT_DRAIN_ON_DONE_EN` defined: `test_done_o` asserts only once the DONE write has landed and the FIFO is empty (code latched immediately; STATUS bit 0 follows `test_done_o`).
- Undefined: `test_done_o` asserts the cycle after the DONE store, regardless of FIFO contents.

## Test plan
- Store 0x41 to 0x100000, `tx_ready_i`=1 -> store_done at +1, `tx_data_o`=0x41 valid one cycle, then empty; STATUS reads 0x0000_0002.
- `tx_ready_i`=0, 17 stores with depth 16 -> 17th drops `dm_ready_o` and holds; raise `tx_ready_i` -> stall clears one cycle after first pop, all 17 bytes emerge in order.
- Store 0xDEAD_BEEF to 0x100004, then 0x1 -> `test_code_o`=0xDEAD_BEEF, `test_done_o`=1, CODE load returns 0xDEAD_BEEF.
- Drain macro on, 3 bytes queued, `tx_ready_i`=0, DONE store -> `test_done_o`=0 until third pop, then 1 next cycle; macro off -> 1 immediately.
- Simultaneous push/pop at count 5 -> count stays 5; store to 0x100010 -> no done pulse, no state change.
- Assert `rst_i` during STALL -> `dm_ready_o`=1, FIFO empty, `test_done_o`=0, no store_done pulse.
